// File: rtl/mic_level_detector.sv
// Microphone level meter: two-stage pipeline that turns centred ADC codes into a
// magnitude, tracks a held/decaying peak and drives an 8-segment thermometer bar.
module mic_level_detector #(
    parameter int HOLD_SAMPLES = 4096,
    parameter int DECAY_STEP   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        mode,
    output logic [10:0] level,
    output logic        level_valid,
    output logic [7:0]  bar,
    output logic        clip
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DECAY
    } state_t;

    localparam logic [15:0] HoldInit  = 16'(HOLD_SAMPLES);
    localparam logic [10:0] DecayStep = 11'(DECAY_STEP);

    logic signed [12:0] centered;
    logic [12:0]        absVal;
    logic [10:0]        magRaw;
    logic               clipRaw;

    logic               valid1_q;
    logic [10:0]        mag1_q;
    logic               clip1_q;

    state_t             state_q, state_d;
    logic [10:0]        peak_q, peak_d;
    logic [15:0]        holdCnt_q, holdCnt_d;
    logic [10:0]        level_q, level_d;
    logic [7:0]         bar_q, bar_d;
    logic               clip_q, clip_d;
    logic               levelValid_q, levelValid_d;

    // Full-scale negative (code 0) has magnitude 2048 and saturates to 2047.
    always_comb begin
        centered = $signed({1'b0, sample}) - 13'sd2048;
        absVal   = centered[12] ? 13'(-centered) : 13'(centered);
        magRaw   = (absVal > 13'd2047) ? 11'd2047 : absVal[10:0];
        clipRaw  = (sample == 12'd0) || (sample == 12'd4095);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid1_q <= 1'b0;
            mag1_q   <= '0;
            clip1_q  <= 1'b0;
        end else begin
            valid1_q <= sample_valid;
            if (sample_valid) begin
                mag1_q  <= magRaw;
                clip1_q <= clipRaw;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        peak_d       = peak_q;
        holdCnt_d    = holdCnt_q;
        level_d      = level_q;
        clip_d       = clip_q;
        levelValid_d = valid1_q;
        bar_d        = '0;

        if (valid1_q) begin
            // A new capture always beats the hold countdown or decay step.
            if (mag1_q >= peak_q) begin
                if (mag1_q != '0) begin
                    peak_d    = mag1_q;
                    holdCnt_d = HoldInit;
                    state_d   = HOLD;
                end
            end else begin
                case (state_q)
                    HOLD: begin
                        holdCnt_d = holdCnt_q - 16'd1;
                        if (holdCnt_q <= 16'd1) begin
                            holdCnt_d = '0;
                            state_d   = DECAY;
                        end
                    end
                    DECAY: begin
                        if (peak_q > DecayStep) begin
                            peak_d = peak_q - DecayStep;
                        end else begin
                            peak_d  = '0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            level_d = mode ? peak_d : mag1_q;
            clip_d  = clip1_q;
        end

        for (int i = 0; i < 8; i++) begin
            bar_d[i] = (int'(level_d) >= 256 * i + 128);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            peak_q       <= '0;
            holdCnt_q    <= '0;
            level_q      <= '0;
            bar_q        <= '0;
            clip_q       <= 1'b0;
            levelValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            peak_q       <= peak_d;
            holdCnt_q    <= holdCnt_d;
            level_q      <= level_d;
            bar_q        <= bar_d;
            clip_q       <= clip_d;
            levelValid_q <= levelValid_d;
        end
    end

    assign level       = level_q;
    assign bar         = bar_q;
    assign clip        = clip_q;
    assign level_valid = levelValid_q;

endmodule

// File: tb/tb_mic_level_detector.sv
// Bench for mic_level_detector: directed scenarios with spec constants plus a
// randomized stream compared against an arithmetic peak-hold reference model.
module tb_mic_level_detector;

    localparam int HOLD  = 4;
    localparam int DECAY = 256;

    typedef struct packed {
        logic        v;
        logic [10:0] l;
        logic [7:0]  b;
        logic        c;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic        mode;
    logic [10:0] level;
    logic        level_valid;
    logic [7:0]  bar;
    logic        clip;

    int   passCount;
    int   checkCount;
    int   mPeak;
    int   mHold;
    rec_t d1, d2, held;
    rec_t obsQ[$];
    rec_t expQ[$];

    mic_level_detector #(
        .HOLD_SAMPLES(HOLD),
        .DECAY_STEP  (DECAY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample      (sample),
        .mode        (mode),
        .level       (level),
        .level_valid (level_valid),
        .bar         (bar),
        .clip        (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: magnitude, then peak capture / hold countdown / decay in plain ints.
    function automatic rec_t modelStep(input int s);
        int   mag;
        int   lvl;
        int   n;
        rec_t r;
        mag = (s >= 2048) ? s - 2048 : 2048 - s;
        if (mag > 2047) mag = 2047;
        if (mag >= mPeak) begin
            if (mag > 0) begin
                mPeak = mag;
                mHold = HOLD;
            end
        end else if (mHold > 0) begin
            mHold = mHold - 1;
        end else begin
            mPeak = (mPeak > DECAY) ? mPeak - DECAY : 0;
        end
        lvl = (mode == 1'b1) ? mPeak : mag;
        n = (lvl < 128) ? 0 : ((lvl - 128) / 256 + 1);
        if (n > 8) n = 8;
        r.v = 1'b1;
        r.l = 11'(lvl);
        r.b = 8'((1 << n) - 1);
        r.c = (s == 0) || (s == 4095);
        return r;
    endfunction

    task automatic modelReset();
        mPeak = 0;
        mHold = 0;
        d1    = '0;
        d2    = '0;
        held  = '0;
    endtask

    task automatic runCycle(input logic v, input logic [11:0] s);
        rec_t e;
        @(negedge clk);
        if (d2.v) held = d2;
        e   = held;
        e.v = d2.v;
        expQ.push_back(e);
        obsQ.push_back({level_valid, level, bar, clip});
        d2 = d1;
        d1 = v ? modelStep(int'(s)) : '0;
        sample_valid = v;
        sample       = s;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checkCount++;
        if ({level_valid, level, bar, clip} !== 21'd0)
            $display("[TB] FAIL reset_outputs: got v=%0b l=%0d b=%h c=%0b, expected all 0", level_valid, level, bar, clip);
        else passCount++;
        reset = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkCount++;
        if ({level_valid, level, bar, clip} !== 21'd0)
            $display("[TB] FAIL reset_release_idle: got v=%0b l=%0d b=%h c=%0b, expected all 0", level_valid, level, bar, clip);
        else passCount++;
    endtask

    task automatic test_instant();
        rec_t want[5];
        want[0] = {1'b1, 11'd1024, 8'h0F, 1'b0};
        want[1] = {1'b1, 11'd0,    8'h00, 1'b0};
        want[2] = {1'b1, 11'd2047, 8'hFF, 1'b1};
        want[3] = {1'b1, 11'd2047, 8'hFF, 1'b1};
        want[4] = {1'b0, 11'd2047, 8'hFF, 1'b1};
        obsQ.delete(); expQ.delete();
        mode = 1'b0;
        runCycle(1'b1, 12'd3072);
        runCycle(1'b1, 12'd2048);
        runCycle(1'b1, 12'd0);
        runCycle(1'b1, 12'd4095);
        repeat (3) runCycle(1'b0, 12'd0);
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if (obsQ[i + 2] !== want[i])
                $display("[TB] FAIL instant[%0d]: got v=%0b l=%0d b=%h c=%0b, expected v=%0b l=%0d b=%h c=%0b", i,
                         obsQ[i + 2].v, obsQ[i + 2].l, obsQ[i + 2].b, obsQ[i + 2].c, want[i].v, want[i].l, want[i].b, want[i].c);
            else passCount++;
        end
    endtask

    task automatic test_peak_hold();
        int lv[7] = '{1024, 1024, 1024, 1024, 1024, 768, 512};
        logic [7:0] bv[7] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h07, 8'h03};
        doReset();
        obsQ.delete(); expQ.delete();
        mode = 1'b1;
        runCycle(1'b1, 12'd3072);
        repeat (6) runCycle(1'b1, 12'd2048);
        repeat (2) runCycle(1'b0, 12'd0);
        for (int i = 0; i < 7; i++) begin
            checkCount++;
            if (obsQ[i + 2] !== {1'b1, 11'(lv[i]), bv[i], 1'b0})
                $display("[TB] FAIL peak_hold[%0d]: got v=%0b l=%0d b=%h, expected v=1 l=%0d b=%h", i,
                         obsQ[i + 2].v, obsQ[i + 2].l, obsQ[i + 2].b, lv[i], bv[i]);
            else passCount++;
        end
    endtask

    task automatic test_decay_to_idle();
        int lv[8] = '{300, 300, 300, 300, 300, 44, 0, 10};
        logic [7:0] bv[8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        doReset();
        obsQ.delete(); expQ.delete();
        mode = 1'b1;
        runCycle(1'b1, 12'd2348);
        repeat (6) runCycle(1'b1, 12'd2048);
        runCycle(1'b1, 12'd2058);
        repeat (2) runCycle(1'b0, 12'd0);
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (obsQ[i + 2] !== {1'b1, 11'(lv[i]), bv[i], 1'b0})
                $display("[TB] FAIL decay_idle[%0d]: got v=%0b l=%0d b=%h, expected v=1 l=%0d b=%h", i,
                         obsQ[i + 2].v, obsQ[i + 2].l, obsQ[i + 2].b, lv[i], bv[i]);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        obsQ.delete(); expQ.delete();
        mode = 1'b0;
        for (int i = 0; i < 16; i++) runCycle(1'b1, (i % 2 == 0) ? 12'd1024 : 12'd3072);
        repeat (3) runCycle(1'b0, 12'd0);
        for (int i = 0; i < 19; i++) begin
            logic wantV;
            wantV = (i >= 2) && (i <= 17);
            checkCount++;
            if (obsQ[i].v !== wantV || (wantV && (obsQ[i].l !== 11'd1024 || obsQ[i].b !== 8'h0F)))
                $display("[TB] FAIL back_to_back[%0d]: got v=%0b l=%0d b=%h, expected v=%0b l=1024 b=0f", i,
                         obsQ[i].v, obsQ[i].l, obsQ[i].b, wantV);
            else passCount++;
        end
    endtask

    task automatic test_random();
        logic [11:0] s;
        logic        v;
        obsQ.delete(); expQ.delete();
        for (int burst = 0; burst < 6; burst++) begin
            mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 150; c++) begin
                v = (burst % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0:       s = 12'd0;
                    1:       s = 12'd4095;
                    2:       s = 12'd2048;
                    3:       s = 12'(2048 + $urandom_range(0, 40) - 20);
                    default: s = 12'($urandom_range(0, 4095));
                endcase
                runCycle(v, s);
            end
            repeat (2) runCycle(1'b0, 12'd0);
        end
        for (int i = 0; i < obsQ.size(); i++) begin
            checkCount++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL random[%0d]: got v=%0b l=%0d b=%h c=%0b, expected v=%0b l=%0d b=%h c=%0b", i,
                         obsQ[i].v, obsQ[i].l, obsQ[i].b, obsQ[i].c, expQ[i].v, expQ[i].l, expQ[i].b, expQ[i].c);
            else passCount++;
        end
    endtask

    task automatic test_reset_inflight();
        mode = 1'b0;
        runCycle(1'b1, 12'd3072);
        repeat (2) runCycle(1'b0, 12'd0);
        runCycle(1'b1, 12'd4095);
        @(negedge clk);
        sample_valid = 1'b0;
        reset        = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if ({level_valid, level, bar, clip} !== 21'd0)
            $display("[TB] FAIL inflight_async_clear: got v=%0b l=%0d b=%h c=%0b, expected all 0", level_valid, level, bar, clip);
        else passCount++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        obsQ.delete(); expQ.delete();
        repeat (4) runCycle(1'b0, 12'd0);
        runCycle(1'b1, 12'd3072);
        repeat (2) runCycle(1'b0, 12'd0);
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (obsQ[i] !== 21'd0)
                $display("[TB] FAIL inflight_discard[%0d]: got v=%0b l=%0d b=%h c=%0b, expected all 0", i,
                         obsQ[i].v, obsQ[i].l, obsQ[i].b, obsQ[i].c);
            else passCount++;
        end
        checkCount++;
        if (obsQ[6] !== {1'b1, 11'd1024, 8'h0F, 1'b0})
            $display("[TB] FAIL post_reset_sample: got v=%0b l=%0d b=%h c=%0b, expected v=1 l=1024 b=0f c=0",
                     obsQ[6].v, obsQ[6].l, obsQ[6].b, obsQ[6].c);
        else passCount++;
    endtask

    initial begin
        passCount    = 0;
        checkCount   = 0;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample       = 12'd0;
        mode         = 1'b0;
        modelReset();
        test_reset();
        test_instant();
        test_peak_hold();
        test_decay_to_idle();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
